// File: rtl/z80_arb_pkg.sv
// Shared definitions for the Z80 bus arbiter.
// Holds the arbiter state encoding, the default cycle constants and a small max helper
// used to size-check the shared counter.
package z80_arb_pkg;

  typedef enum logic [2:0] {
    StRstHold = 3'd0,
    StCpuOwn  = 3'd1,
    StReqBus  = 3'd2,
    StExtOwn  = 3'd3,
    StRelease = 3'd4
  } arb_state_e;

  localparam int unsigned DefResetCycles   = 16;
  localparam int unsigned DefMinCpuCycles  = 64;
  localparam int unsigned DefTimeoutCycles = 200000;
  localparam int unsigned DefCntW          = 18;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser with a parameterised reset value.
// Ports: clk (sampling clock), reset (synchronous, active-high), d (asynchronous input),
//        q (synchronised output, two clk cycles behind d).
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/z80_bus_arbiter.sv
// Z80 bus arbiter: owns nRESET/nBUSRQ/nBUSAK, sequences CPU reset release and shares the
// CPU bus with one external requester through a level req/gnt handshake.
// Ports: mclk (clock), reset (synchronous, active-high), cpu_nbusak (raw Z80 nBUSAK),
//        cpu_nreset / cpu_nbusrq (Z80 control), ext_req / ext_gnt (external handshake),
//        bus_sel_ext (bus mux select, 1 = external), arb_err (sticky ack-timeout flag).
// Build option: define Z80_ARB_TIMEOUT_EN to abort a bus request that is not acknowledged
// within TIMEOUT_CYCLES; otherwise the request waits forever and arb_err is tied low.
module z80_bus_arbiter
  import z80_arb_pkg::*;
#(
  parameter int unsigned RESET_CYCLES   = DefResetCycles,
  parameter int unsigned MIN_CPU_CYCLES = DefMinCpuCycles,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles,
  parameter int unsigned CNT_W          = DefCntW
) (
  input  logic mclk,
  input  logic reset,
  input  logic cpu_nbusak,
  output logic cpu_nreset,
  output logic cpu_nbusrq,
  input  logic ext_req,
  output logic ext_gnt,
  output logic bus_sel_ext,
  output logic arb_err
);

  localparam int unsigned CntNeed = max3(RESET_CYCLES, MIN_CPU_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] RstLast = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] MinLoad = CNT_W'(MIN_CPU_CYCLES);

  if ((CntNeed >> CNT_W) != 0) begin : g_cnt_w_check
    $error("CNT_W too narrow for the configured cycle counts");
  end

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ak_s;
  logic             nreset_q, nbusrq_q, ext_own_q;

  sync2 #(
    .RESET_VAL(1'b1)
  ) u_ak_sync (
    .clk  (mclk),
    .reset(reset),
    .d    (cpu_nbusak),
    .q    (ak_s)
  );

`ifdef Z80_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] ReqLoad = CNT_W'(TIMEOUT_CYCLES);
  logic err_set;
  logic err_q;
`else
  localparam logic [CNT_W-1:0] ReqLoad = '0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef Z80_ARB_TIMEOUT_EN
    err_set = 1'b0;
`endif
    unique case (state_q)
      // Counts up from the reset value of 0, so the hold lasts RESET_CYCLES edges.
      StRstHold: begin
        if (cnt_q >= RstLast) begin
          state_d = StCpuOwn;
          cnt_d   = MinLoad;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // A request seen while the window is open is simply held off until cnt_q hits 0.
      StCpuOwn: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (ext_req) begin
          state_d = StReqBus;
          cnt_d   = ReqLoad;
        end
      end
      // A withdrawn request beats a simultaneous acknowledge.
      StReqBus: begin
        if (!ext_req) begin
          state_d = StCpuOwn;
          cnt_d   = '0;
        end else if (!ak_s) begin
          state_d = StExtOwn;
          cnt_d   = '0;
`ifdef Z80_ARB_TIMEOUT_EN
        end else if (cnt_q <= CNT_W'(1)) begin
          state_d = StCpuOwn;
          cnt_d   = MinLoad;
          err_set = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
`endif
        end
      end
      StExtOwn: begin
        if (!ext_req) begin
          state_d = StRelease;
          cnt_d   = '0;
        end
      end
      StRelease: begin
        if (ak_s) begin
          state_d = StCpuOwn;
          cnt_d   = MinLoad;
        end
      end
      default: begin
        state_d = StRstHold;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they switch on the same edge as the
  // state register, without decode glitches on the pins.
  always_ff @(posedge mclk) begin
    if (reset) begin
      state_q   <= StRstHold;
      cnt_q     <= '0;
      nreset_q  <= 1'b0;
      nbusrq_q  <= 1'b1;
      ext_own_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      nreset_q  <= (state_d != StRstHold);
      nbusrq_q  <= !((state_d == StReqBus) || (state_d == StExtOwn));
      ext_own_q <= (state_d == StExtOwn);
    end
  end

`ifdef Z80_ARB_TIMEOUT_EN
  always_ff @(posedge mclk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end
  assign arb_err = err_q;
`else
  assign arb_err = 1'b0;
`endif

  assign cpu_nreset  = nreset_q;
  assign cpu_nbusrq  = nbusrq_q;
  assign ext_gnt     = ext_own_q;
  assign bus_sel_ext = ext_own_q;

endmodule
